// File: rtl/switch_input_ctrl.sv
// Board switch/button input peripheral: 2-FF sync, shared debounce, enter-edge capture, MMIO read port.
// Optional feature macro: SWITCH_DEBOUNCE_EN (defined = debounce counter; undefined = deb_vec is sync_vec).
module switch_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [23:0] switches_raw,
  input  logic [4:0]  buttons_raw,
  input  logic        mmio_read,
  input  logic [1:0]  mmio_addr,
  output logic [31:0] mmio_rdata,
  output logic        mmio_rvalid
);

  localparam int unsigned VEC_W = 29;

  typedef enum logic [0:0] {
    WAIT_HIGH = 1'b0,
    HELD      = 1'b1
  } state_t;

  logic [VEC_W-1:0] sync1_q, sync2_q;
  logic [VEC_W-1:0] deb_vec_s;
  logic             enter_s;

  // Two-stage synchronizer; vector is {buttons, switches}
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {buttons_raw, switches_raw};
      sync2_q <= sync1_q;
    end
  end

`ifdef SWITCH_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [VEC_W-1:0] prev_q, deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Loading on the edge the count reaches its limit makes deb_vec follow
  // a stable raw change after exactly 2 + DEBOUNCE_CYCLES edges.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if (cnt_d == CNT_MAX) begin
      deb_d = sync2_q;
    end else begin
      deb_d = deb_q;
    end
  end

  // Debounce state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      cnt_q  <= '0;
      deb_q  <= '0;
    end else begin
      prev_q <= sync2_q;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign deb_vec_s = deb_q;
`else
  assign deb_vec_s = sync2_q;
`endif

  assign enter_s = deb_vec_s[20];

  state_t      state_q, state_d;
  logic [15:0] operand_q, operand_d;
  logic [2:0]  case_sel_q, case_sel_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  logic        mmio_rvalid_q, mmio_rvalid_d;
  logic        capture_s, rd_op_s, rd_stat_s;
  logic [31:0] rd_mux_s;

  // Capture FSM, read-to-clear flags and read data path
  always_comb begin
    state_d       = state_q;
    operand_d     = operand_q;
    case_sel_d    = case_sel_q;
    capture_s     = 1'b0;
    rd_op_s       = mmio_read && (mmio_addr == 2'd0);
    rd_stat_s     = mmio_read && (mmio_addr == 2'd2);
    rd_mux_s      = 32'h0;
    mmio_rdata_d  = mmio_rdata_q;
    mmio_rvalid_d = mmio_read;

    case (state_q)
      WAIT_HIGH: begin
        if (enter_s) begin
          capture_s  = 1'b1;
          operand_d  = deb_vec_s[15:0];
          case_sel_d = deb_vec_s[23:21];
          state_d    = HELD;
        end else begin
          state_d = WAIT_HIGH;
        end
      end
      HELD: begin
        if (!enter_s) begin
          state_d = WAIT_HIGH;
        end else begin
          state_d = HELD;
        end
      end
      default: state_d = WAIT_HIGH;
    endcase

    // A capture coinciding with an operand read counts as consumed, not overrun
    if (capture_s) begin
      valid_d = 1'b1;
    end else if (rd_op_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (capture_s && valid_q && !rd_op_s) begin
      overrun_d = 1'b1;
    end else if (rd_stat_s) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    case (mmio_addr)
      2'd0:    rd_mux_s = {16'h0, operand_q};
      2'd1:    rd_mux_s = {29'h0, case_sel_q};
      2'd2:    rd_mux_s = {23'h0, deb_vec_s[28:24], 1'b0, enter_s, overrun_q, valid_q};
      2'd3:    rd_mux_s = {8'h0, deb_vec_s[23:0]};
      default: rd_mux_s = 32'h0;
    endcase

    if (mmio_read) begin
      mmio_rdata_d = rd_mux_s;
    end else begin
      mmio_rdata_d = mmio_rdata_q;
    end
  end

  // Capture, flag and read-port registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WAIT_HIGH;
      operand_q     <= 16'h0;
      case_sel_q    <= 3'h0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      mmio_rdata_q  <= 32'h0;
      mmio_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      operand_q     <= operand_d;
      case_sel_q    <= case_sel_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
      mmio_rdata_q  <= mmio_rdata_d;
      mmio_rvalid_q <= mmio_rvalid_d;
    end
  end

  assign mmio_rdata  = mmio_rdata_q;
  assign mmio_rvalid = mmio_rvalid_q;

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Directed self-checking bench for switch_input_ctrl; timing adapts to SWITCH_DEBOUNCE_EN.
module tb_switch_input_ctrl;

  localparam int DEB = 16;
`ifdef SWITCH_DEBOUNCE_EN
  localparam int CAP = DEB + 3;
`else
  localparam int CAP = 3;
`endif
  localparam int SETTLE = CAP + 7;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] switches_raw = 24'h0;
  logic [4:0]  buttons_raw = 5'h0;
  logic        mmio_read = 1'b0;
  logic [1:0]  mmio_addr = 2'd0;
  logic [31:0] mmio_rdata;
  logic        mmio_rvalid;

  int n_cmp = 0;
  int n_bad = 0;

  switch_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .switches_raw(switches_raw), .buttons_raw(buttons_raw),
    .mmio_read(mmio_read), .mmio_addr(mmio_addr), .mmio_rdata(mmio_rdata), .mmio_rvalid(mmio_rvalid)
  );

  always #5 clock = ~clock;

  // Called just after a negedge: one-cycle strobe, then data and single-pulse rvalid observed
  task automatic do_read(input logic [1:0] a, output logic [31:0] d, output logic ok);
    logic r1, r2;
    mmio_read = 1'b1;
    mmio_addr = a;
    @(negedge clock);
    mmio_read = 1'b0;
    d  = mmio_rdata;
    r1 = mmio_rvalid;
    @(negedge clock);
    r2 = mmio_rvalid;
    ok = r1 && !r2;
  endtask

  task automatic settle();
    repeat (SETTLE) @(negedge clock);
  endtask

  task automatic press(input logic [23:0] opnd);
    switches_raw = opnd;
    settle();
    switches_raw = opnd | 24'h100000;
    settle();
    switches_raw = opnd;
    settle();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic ok;
    #1;
    n_cmp++;
    if ({mmio_rvalid, mmio_rdata} !== 33'h0) begin
      n_bad++; $display("FAIL reset_outputs: got rvalid=%b rdata=%h want 0/0", mmio_rvalid, mmio_rdata);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      do_read(a[1:0], d, ok);
      n_cmp++;
      if ({ok, d} !== {1'b1, 32'h0}) begin
        n_bad++; $display("FAIL reset_read%0d: got pulse_ok=%b data=%h want 1/%h", a, ok, d, 32'h0);
      end
    end
  endtask

  task automatic test_capture();
    logic [31:0] d;
    logic ok;
    switches_raw = 24'h000001;
    settle();
    switches_raw = 24'h100001;
    settle();
    do_read(2'd2, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h5}) begin
      n_bad++; $display("FAIL cap_status: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h5);
    end
    do_read(2'd0, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h1}) begin
      n_bad++; $display("FAIL cap_operand: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h1);
    end
    do_read(2'd2, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h4}) begin
      n_bad++; $display("FAIL cap_status_cleared: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h4);
    end
    switches_raw = 24'h0;
    settle();
  endtask

  task automatic test_glitch();
`ifdef SWITCH_DEBOUNCE_EN
    logic [31:0] d;
    logic ok;
    for (int i = 0; i < 10; i++) begin
      switches_raw[20] = ~switches_raw[20];
      repeat (DEB / 2) @(negedge clock);
    end
    settle();
    do_read(2'd2, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL glitch_status: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h0);
    end
    do_read(2'd3, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL glitch_live: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h0);
    end
`endif
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic ok;
    press(24'h000003);
    press(24'h000007);
    do_read(2'd2, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h3}) begin
      n_bad++; $display("FAIL ovr_status: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h3);
    end
    do_read(2'd0, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h7}) begin
      n_bad++; $display("FAIL ovr_operand: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h7);
    end
    do_read(2'd2, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL ovr_cleared: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h0);
    end
    // Overrun set coinciding with a status read: the set must survive
    press(24'h000009);
    switches_raw = 24'h10000A;
    repeat (CAP - 1) @(negedge clock);
    do_read(2'd2, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h5}) begin
      n_bad++; $display("FAIL ovr_race_read: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h5);
    end
    do_read(2'd2, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h7}) begin
      n_bad++; $display("FAIL ovr_race_set: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h7);
    end
    switches_raw = 24'h00000A;
    settle();
    do_read(2'd0, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'hA}) begin
      n_bad++; $display("FAIL ovr_race_operand: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'hA);
    end
    do_read(2'd2, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL ovr_race_final: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h0);
    end
  endtask

  task automatic test_simul_read();
    logic [31:0] d;
    logic ok;
    press(24'h000011);
    switches_raw = 24'h100022;
    repeat (CAP - 1) @(negedge clock);
    do_read(2'd0, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h11}) begin
      n_bad++; $display("FAIL simul_old_operand: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h11);
    end
    do_read(2'd2, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h5}) begin
      n_bad++; $display("FAIL simul_status: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h5);
    end
    do_read(2'd0, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h22}) begin
      n_bad++; $display("FAIL simul_new_operand: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h22);
    end
    do_read(2'd2, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h4}) begin
      n_bad++; $display("FAIL simul_cleared: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h4);
    end
    switches_raw = 24'h000022;
    settle();
  endtask

  task automatic test_case_sel();
    logic [31:0] d;
    logic ok;
    switches_raw = 24'hA00042;
    buttons_raw  = 5'h0A;
    settle();
    switches_raw = 24'hB00042;
    settle();
    do_read(2'd1, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h5}) begin
      n_bad++; $display("FAIL case_sel: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h5);
    end
    do_read(2'd3, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h00B00042}) begin
      n_bad++; $display("FAIL case_live: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h00B00042);
    end
    do_read(2'd2, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'hA5}) begin
      n_bad++; $display("FAIL case_status: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'hA5);
    end
    do_read(2'd0, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h42}) begin
      n_bad++; $display("FAIL case_operand: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h42);
    end
    // Operand change while enter stays high must not recapture
    switches_raw = 24'hB00055;
    settle();
    do_read(2'd2, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'hA4}) begin
      n_bad++; $display("FAIL case_held: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'hA4);
    end
    buttons_raw  = 5'h0;
    switches_raw = 24'h0;
    settle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic ok;
    int first;
    int pulses;
    switches_raw = 24'h000055;
    settle();
    switches_raw = 24'h100055;
    settle();
    switches_raw = 24'h100056;
    repeat (CAP / 2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({mmio_rvalid, mmio_rdata} !== 33'h0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got rvalid=%b rdata=%h want 0/0", mmio_rvalid, mmio_rdata);
    end
    @(negedge clock);
    reset_n   = 1'b1;
    mmio_read = 1'b1;
    mmio_addr = 2'd2;
    first  = 0;
    pulses = 0;
    for (int n = 1; n <= CAP + 20 && first == 0; n++) begin
      @(negedge clock);
      if (mmio_rvalid) pulses++;
      if (n == 1) begin
        n_cmp++;
        if (mmio_rdata !== 32'h0) begin
          n_bad++; $display("FAIL mid_first_status: got %h want %h", mmio_rdata, 32'h0);
        end
      end
      if (mmio_rdata[0]) first = n;
    end
    mmio_read = 1'b0;
    n_cmp++;
    if (first !== CAP + 1) begin
      n_bad++; $display("FAIL mid_recapture_time: got read %0d want read %0d (0 = timeout)", first, CAP + 1);
    end
    n_cmp++;
    if (pulses !== first) begin
      n_bad++; $display("FAIL mid_b2b_rvalid: got %0d pulses want %0d", pulses, first);
    end
    do_read(2'd0, d, ok);
    n_cmp++;
    if ({ok, d} !== {1'b1, 32'h56}) begin
      n_bad++; $display("FAIL mid_operand: got pulse_ok=%b data=%h want 1/%h", ok, d, 32'h56);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_glitch();
    test_overrun();
    test_simul_read();
    test_case_sel();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_input_ctrl.md
# switch_input_ctrl

Memory-mapped input peripheral that brings the Minisys board switches and buttons into the MIPS CPU clock domain. It synchronizes, debounces and edge-detects them, and latches the operand and case select on each rising edge of the enter switch (bit 20). It presents the captured values to the CPU through a registered MMIO read port with a read-to-clear valid flag. It sits between the board pins and the CPU data-memory bus, on the receiving side of the switch stimulus that drives the board.

## Interface
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required before the debounced vector updates; must be at least 2.
- CNT_W, 16: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- clock  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- switches_raw  in  24  raw switches: [23:21] case select, [20] enter, [15:0] operand, [19:16] unused.
- buttons_raw  in  5  raw buttons.
- mmio_read  in  1  one-cycle read strobe from the CPU.
- mmio_addr  in  2  register select, sampled with mmio_read.
- mmio_rdata  out  32  registered read data.
- mmio_rvalid  out  1  high for exactly one cycle, the cycle after mmio_read.

## Operation
- Synchronization: a 2-FF synchronizer on all 29 input bits (24 switches + 5 buttons), giving sync_vec.
- Debounce: one shared counter covers the whole vector.
  - The counter clears whenever sync_vec differs from its previous-cycle value.
  - Otherwise it increments, saturating at DEBOUNCE_CYCLES-1.
  - When the counter equals DEBOUNCE_CYCLES-1, deb_vec <= sync_vec.
- Capture FSM uses deb_vec[20] (enter):
  - WAIT_HIGH: on enter=1, capture operand <= deb[15:0] and case_sel <= deb[23:21]; if valid is already 1, set overrun; set valid; go to HELD.
  - HELD: on enter=0, go to WAIT_HIGH. Switch changes while in HELD are not captured.
- Register map (read only):
  - 0: {16'h0, operand}. Reading clears valid.
  - 1: {29'h0, case_sel}.
  - 2: {23'h0, deb_buttons[4:0], 1'b0, enter_level, overrun, valid}. Reading clears overrun.
  - 3: {8'h0, deb_switches[23:0]}, live value.
- Writes are not supported; the CPU address decoder must not route stores here.
- Reset values:
  - mmio_rdata=0, mmio_rvalid=0, valid=0, overrun=0, operand=0, case_sel=0.
  - Synchronizers, deb_vec and counter all 0. FSM in WAIT_HIGH.
- Reset asserted mid-debounce or mid-capture discards all state. After release, an enter switch that is already high is captured once it has been debounced.

## Timing
- Raw change to deb_vec update: 2 synchronizer cycles plus DEBOUNCE_CYCLES cycles, provided raw stays stable. Any toggle restarts the count.
- deb enter rise to capture (operand, case_sel, valid updated): 1 cycle.
- Read latency is 1 cycle: mmio_rdata and mmio_rvalid are updated on the edge that samples mmio_read.
- mmio_rdata holds its value until the next read.
- Read-to-clear takes effect on the same edge, so a read of addr 2 in the following cycle already shows the cleared bit.
- Simultaneous capture and addr-0 read on one edge:
  - Capture wins: valid stays 1 and overrun is not set.
  - mmio_rdata returns the pre-capture operand.
- Simultaneous overrun-set and addr-2 read: the set wins.
- Back-to-back reads on consecutive cycles are legal; each returns one rvalid pulse.

## Configuration
- SWITCH_DEBOUNCE_EN defined: the debounce counter and deb_vec are implemented as above.
- Undefined: deb_vec = sync_vec directly, with no counter logic.
  - Raw-to-capture latency drops to 3 cycles.
  - All other behaviour is unchanged. Intended for fast CPU-level simulation.

## Test plan
- Reset, then read addrs 0-3 -> every read returns 32'h0; rvalid pulses once per read.
- switches 24'h000001, then set bit 20 and hold for DEBOUNCE_CYCLES+10 cycles -> addr 2 reads 32'h5 (valid, enter_level); addr 0 reads 32'h1; the next addr 2 read returns 32'h4.
- Toggle bit 20 every DEBOUNCE_CYCLES/2 cycles for 10 toggles -> no capture; addr 2 bit0 stays 0.
- Two enter presses (operand 3, then 7) without reading -> addr 2 reads 32'h3 (overrun+valid), or 32'h7 if enter is still high; addr 0 reads 32'h7; a second addr 2 read shows overrun cleared.
- Switches 24'hA0_0042 with enter pressed -> addr 1 reads 32'h5 and addr 3 reads 32'h00B00042 while enter is held.
- Assert reset_n low for 1 cycle while valid=1 and the counter is mid-count -> all registers read 0. With enter still high, capture recurs DEBOUNCE_CYCLES+3 cycles after release.
